axis_unpack_256to128: RTL and testbench
=======================================

Name: axis_unpack_256to128

Overview:
- Width-splitting AXI4-Stream unpacker: accepts 256-bit beats and emits each as two 128-bit beats, lower half first.
- It is the counterpart of the 128→256 stacker that feeds the DAC streams. It serves as the loopback and replay path that takes DAC-width (256-bit, 16 samples) words back down to ADC-width (128-bit, 8 samples) streams.
- Single clock domain (aclk, 375 MHz).
- Optionally holds off until a registered SYSREF rising edge, so the half-word phase is deterministic across channels.
- Counts output starvation cycles for debug.

Parameters:
- ALIGN_SYSREF, 1, when 1 the block starts in WAIT_SYNC and enters RUN on the first sysref rising edge; when 0 it enters RUN directly out of reset.
- UFLOW_W, 16, width of the saturating underflow counter.

Ports:
- aclk  input  1  stream clock; all logic rises on it.
- aresetn  input  1  synchronous active-low reset.
- sysref_i  input  1  SYSREF already registered into aclk; level signal.
- s_axis_tdata  input  256  input word; bits [127:0] are sent first, bits [255:128] second.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- m_axis_tdata  output  128  output half-word.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  downstream ready.
- aligned_o  output  1  high while in RUN.
- uflow_count_o  output  UFLOW_W  saturating count of starvation cycles.
- uflow_clr_i  input  1  synchronous clear of uflow_count_o.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - All outputs go to 0: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, aligned_o=0, uflow_count_o=0.
  - Any held word is discarded; the phase bit returns to 0.
  - State becomes WAIT_SYNC if ALIGN_SYSREF=1, otherwise RUN.
  - The sysref edge-detect register is cleared.
- Storage:
  - hold register: 256 bits.
  - full flag.
  - phase bit: 0 = low half pending, 1 = high half pending.
- Output data path:
  - m_axis_tdata = phase ? hold[255:128] : hold[127:0].
  - m_axis_tvalid = full.
  - Both are registered-state driven; there is no combinational path from s_axis to m_axis.
- State WAIT_SYNC:
  - s_axis_tready=0, full stays 0, aligned_o=0.
  - A rising edge is sysref_i=1 while the previous-cycle sample was 0. On that edge the state moves to RUN on the next edge.
  - A sysref_i that is high out of reset does not count; a 0→1 transition is required.
- State RUN:
  - aligned_o=1.
  - s_axis_tready = !full | (phase & m_axis_tready), computed combinationally.
  - Input accept (s_axis_tvalid & s_axis_tready): hold <= s_axis_tdata, full <= 1, phase <= 0.
  - Output handshake with phase=0: phase <= 1.
  - Output handshake with phase=1 and no simultaneous accept: full <= 0, phase <= 0.
  - Output handshake with phase=1 and a simultaneous accept: the new word loads, full stays 1, phase <= 0. This gives zero-bubble back-to-back operation.
  - Sustained throughput: one 256-bit input every 2 cycles; one 128-bit output every cycle.
  - Latency: an input accepted at edge N gives its low half valid at edge N+1, and the high half is offered the cycle after the low-half handshake.
  - RUN is sticky; only reset returns the block to WAIT_SYNC. Sysref edges in RUN are ignored.
- AXI4-Stream rules:
  - m_axis_tvalid never deasserts and m_axis_tdata never changes while m_axis_tvalid=1 and m_axis_tready=0.
  - s_axis_tready may depend combinationally on m_axis_tready.
- Underflow counter:
  - Increments in RUN on every cycle where m_axis_tready=1 and m_axis_tvalid=0.
  - Saturates at all-ones.
  - uflow_clr_i=1 forces it to 0, taking priority over an increment in the same cycle.
  - No counting occurs in WAIT_SYNC.
- Reset mid-operation: a pending high half is dropped and is never emitted.

Test Plan:
- ALIGN_SYSREF=1, sysref_i held at 0, s_axis_tvalid=1 → s_axis_tready=0 and aligned_o=0 for 100 cycles. Then pulse sysref_i 0→1 → aligned_o=1 two edges later, and the first word is accepted.
- RUN, m_axis_tready=1, input words W0=0x…0002_…0001 (hi=2, lo=1) and W1 (hi=4, lo=3) presented continuously → m_axis_tdata sequence 1,2,3,4 on consecutive cycles, m_axis_tvalid constant 1, s_axis_tready toggling 1,0,1,0.
- Backpressure: m_axis_tready=0 for 5 cycles with phase=1 → m_axis_tdata held at the high half, s_axis_tready=0. Then release → the high half is transferred and the next word loads in the same cycle.
- Starvation: RUN, s_axis_tvalid=0, m_axis_tready=1 for 10 cycles → uflow_count_o=10. Assert uflow_clr_i together with a starvation cycle → count=0. Preload to 0xFFFF (UFLOW_W=16) → the counter stays at 0xFFFF.
- Reset mid-word: assert aresetn=0 after the low-half handshake → after reset, m_axis_tvalid=0 and the high half is never emitted. With ALIGN_SYSREF=0 the block is in RUN immediately and the next input's low half appears first.
- Randomized tvalid/tready (50%) on 1000 words, checked against a scoreboard → output equals the inputs split low-then-high, with no loss or duplication.

Source files
------------

// File: rtl/axis_unpack_256to128_if.sv
// AXI4-Stream data/handshake bundle, parameterised by data width.
// The master modport drives tdata/tvalid. The slave modport drives tready.
interface axis_unpack_256to128_if #(
    parameter int DATA_W = 128
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_unpack_256to128.sv
// Splits each 256-bit AXI4-Stream beat into two 128-bit beats, low half first.
// It can optionally wait for a SYSREF rising edge, and it counts output starvation cycles.
module axis_unpack_256to128 #(
    parameter bit ALIGN_SYSREF = 1'b1,
    parameter int UFLOW_W      = 16,
    parameter int DATA_W       = 128
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   sysref_i,
    input  logic                   uflow_clr_i,
    output logic                   aligned_o,
    output logic [UFLOW_W-1:0]     uflow_count_o,
    axis_unpack_256to128_if.slave  s_axis,
    axis_unpack_256to128_if.master m_axis
);
    typedef enum logic {WAIT_SYNC = 1'b0, RUN = 1'b1} state_t;

    state_t              r_state;
    logic                r_aligned;
    logic                r_sysref_d;
    logic                r_sysref_vld;
    logic                r_sysref_rise;
    logic                r_full;
    logic                r_phase;
    logic [2*DATA_W-1:0] r_hold;
    logic [UFLOW_W-1:0]  r_uflow;

    logic w_accept;
    logic w_out_hs;
    logic w_starve;
    logic w_uflow_sat;

    // A new word may load while the last (high) half is leaving in the same cycle.
    assign s_axis.tready = r_aligned & (~r_full | (r_phase & m_axis.tready));
    assign w_accept      = s_axis.tvalid & s_axis.tready;
    assign w_out_hs      = r_full & m_axis.tready;
    assign w_starve      = r_aligned & m_axis.tready & ~r_full;
    assign w_uflow_sat   = &r_uflow;

    assign m_axis.tvalid = r_full;
    assign m_axis.tdata  = !r_full ? '0 :
                           (r_phase ? r_hold[2*DATA_W-1:DATA_W] : r_hold[DATA_W-1:0]);
    assign aligned_o     = r_aligned;
    assign uflow_count_o = r_uflow;

    always_ff @(posedge aclk) begin
        if (w_accept) begin
            r_hold <= s_axis.tdata;
        end

        if (!aresetn) begin
            r_state       <= ALIGN_SYSREF ? WAIT_SYNC : RUN;
            r_aligned     <= 1'b0;
            r_sysref_d    <= 1'b0;
            r_sysref_vld  <= 1'b0;
            r_sysref_rise <= 1'b0;
            r_full        <= 1'b0;
            r_phase       <= 1'b0;
            r_uflow       <= '0;
        end else begin
            // The edge is qualified with a valid previous sample, so a level that is already high out of reset is not an edge.
            r_sysref_d    <= sysref_i;
            r_sysref_vld  <= 1'b1;
            r_sysref_rise <= sysref_i & ~r_sysref_d & r_sysref_vld;

            case (r_state)
                WAIT_SYNC: begin
                    if (r_sysref_rise) begin
                        r_state   <= RUN;
                        r_aligned <= 1'b1;
                    end
                end
                RUN: begin
                    r_aligned <= 1'b1;
                end
                default: begin
                    r_state <= ALIGN_SYSREF ? WAIT_SYNC : RUN;
                end
            endcase

            if (w_accept) begin
                r_full  <= 1'b1;
                r_phase <= 1'b0;
            end else if (w_out_hs) begin
                if (r_phase) begin
                    r_full <= 1'b0;
                end
                r_phase <= ~r_phase;
            end

            if (uflow_clr_i) begin
                r_uflow <= '0;
            end else if (w_starve && !w_uflow_sat) begin
                r_uflow <= r_uflow + UFLOW_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_axis_unpack_256to128.sv
// Directed bench for axis_unpack_256to128, with a SYSREF-aligned instance and a free-running instance.
// It also runs a randomized handshake section that is checked against a queue of expected halves.
module tb_axis_unpack_256to128;
    logic        clk = 1'b0;
    logic        rstn;
    logic        sysref;
    logic        clr0, clr1;
    logic        aligned0, aligned1;
    logic [15:0] uf0;
    logic [3:0]  uf1;

    int checks   = 0;
    int failures = 0;

    axis_unpack_256to128_if #(.DATA_W(256)) s0 ();
    axis_unpack_256to128_if #(.DATA_W(128)) m0 ();
    axis_unpack_256to128_if #(.DATA_W(256)) s1 ();
    axis_unpack_256to128_if #(.DATA_W(128)) m1 ();

    always #5 clk = ~clk;

    axis_unpack_256to128 #(.ALIGN_SYSREF(1'b1), .UFLOW_W(16), .DATA_W(128)) dut0 (
        .aclk(clk), .aresetn(rstn), .sysref_i(sysref), .uflow_clr_i(clr0),
        .aligned_o(aligned0), .uflow_count_o(uf0), .s_axis(s0), .m_axis(m0)
    );

    axis_unpack_256to128 #(.ALIGN_SYSREF(1'b0), .UFLOW_W(4), .DATA_W(128)) dut1 (
        .aclk(clk), .aresetn(rstn), .sysref_i(sysref), .uflow_clr_i(clr1),
        .aligned_o(aligned1), .uflow_count_o(uf1), .s_axis(s1), .m_axis(m1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [255:0] word(input logic [127:0] hi, input logic [127:0] lo);
        return {hi, lo};
    endfunction

    initial begin
        logic [127:0] q[$];
        logic [127:0] exp_half;
        logic         acc, hs;
        int           sent, got, cyc;

        rstn = 1'b0; sysref = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        s0.tvalid = 1'b0; s0.tdata = '0; m0.tready = 1'b0;
        s1.tvalid = 1'b0; s1.tdata = '0; m1.tready = 1'b0;
        repeat (3) step();

        chk("rst_tready0", 128'(s0.tready), 128'(0));
        chk("rst_tvalid0", 128'(m0.tvalid), 128'(0));
        chk("rst_tdata0", m0.tdata, 128'(0));
        chk("rst_aligned0", 128'(aligned0), 128'(0));
        chk("rst_uflow0", 128'(uf0), 128'(0));
        chk("rst_aligned1", 128'(aligned1), 128'(0));
        chk("rst_tvalid1", 128'(m1.tvalid), 128'(0));

        // Waiting for SYSREF: no input is accepted, even though valid and downstream ready are high.
        rstn = 1'b1;
        s0.tvalid = 1'b1; s0.tdata = word(128'd2, 128'd1); m0.tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("wait_tready0", 128'(s0.tready), 128'(0));
            chk("wait_aligned0", 128'(aligned0), 128'(0));
        end
        chk("wait_uflow0", 128'(uf0), 128'(0));
        chk("free_aligned1", 128'(aligned1), 128'(1));
        m0.tready = 1'b0;

        sysref = 1'b1;
        step();
        chk("sync_e1_aligned0", 128'(aligned0), 128'(0));
        chk("sync_e1_tready0", 128'(s0.tready), 128'(0));
        step();
        chk("sync_e2_aligned0", 128'(aligned0), 128'(1));
        chk("sync_e2_tready0", 128'(s0.tready), 128'(1));
        step();
        chk("w0_lo_tvalid", 128'(m0.tvalid), 128'(1));
        chk("w0_lo_tdata", m0.tdata, 128'd1);
        chk("w0_lo_tready", 128'(s0.tready), 128'(0));

        // Streaming at full rate: the output beats run 1,2,3,4 and tready alternates.
        m0.tready = 1'b1; s0.tdata = word(128'd4, 128'd3);
        #1 chk("str_tready_a", 128'(s0.tready), 128'(0));
        step();
        chk("str_tdata_2", m0.tdata, 128'd2);
        #1 chk("str_tready_b", 128'(s0.tready), 128'(1));
        step();
        chk("str_tdata_3", m0.tdata, 128'd3);
        chk("str_tvalid_3", 128'(m0.tvalid), 128'(1));
        s0.tdata = word(128'd6, 128'd5);
        #1 chk("str_tready_c", 128'(s0.tready), 128'(0));
        step();
        chk("str_tdata_4", m0.tdata, 128'd4);
        chk("str_tvalid_4", 128'(m0.tvalid), 128'(1));

        // Backpressure with the high half pending.
        m0.tready = 1'b0;
        #1 chk("bp_tready", 128'(s0.tready), 128'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_tdata", m0.tdata, 128'd4);
            chk("bp_tvalid", 128'(m0.tvalid), 128'(1));
            chk("bp_tready_hold", 128'(s0.tready), 128'(0));
        end
        m0.tready = 1'b1;
        #1 chk("bp_rel_tready", 128'(s0.tready), 128'(1));
        step();
        chk("bp_rel_tdata_5", m0.tdata, 128'd5);
        s0.tvalid = 1'b0;
        step();
        chk("drain_tdata_6", m0.tdata, 128'd6);
        step();
        chk("drain_tvalid", 128'(m0.tvalid), 128'(0));
        chk("pre_starve_uflow0", 128'(uf0), 128'(0));

        // Starvation counting, followed by a clear that wins over a counting cycle.
        repeat (10) step();
        chk("starve_uflow0_10", 128'(uf0), 128'd10);
        clr0 = 1'b1;
        step();
        chk("starve_clr_uflow0", 128'(uf0), 128'(0));
        clr0 = 1'b0;

        // Randomized handshakes on 1000 words, checked against a queue of halves.
        sent = 0; got = 0; cyc = 0;
        s0.tvalid = 1'b0;
        while (got < 2000 && cyc < 20000) begin
            #1;
            acc = s0.tvalid & s0.tready;
            hs  = m0.tvalid & m0.tready;
            if (hs) begin
                if (q.size() == 0) begin
                    chk("rand_unexpected_beat", m0.tdata, 128'hx);
                end else begin
                    exp_half = q.pop_front();
                    chk("rand_tdata", m0.tdata, exp_half);
                end
                got++;
            end
            if (acc) begin
                q.push_back(s0.tdata[127:0]);
                q.push_back(s0.tdata[255:128]);
                sent++;
            end
            step();
            cyc++;
            if (acc || !s0.tvalid) begin
                s0.tvalid = (sent < 1000) && ($urandom_range(1) == 1);
                s0.tdata  = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            end
            m0.tready = ($urandom_range(1) == 1);
        end
        chk("rand_words_sent", 128'(sent), 128'd1000);
        chk("rand_halves_got", 128'(got), 128'd2000);
        chk("rand_queue_empty", 128'(q.size()), 128'd0);
        s0.tvalid = 1'b0; m0.tready = 1'b0;

        // Saturation on the 4-bit counter of the free-running instance.
        chk("sat_uflow1_start", 128'(uf1), 128'(0));
        m1.tready = 1'b1;
        repeat (15) step();
        chk("sat_uflow1_15", 128'(uf1), 128'd15);
        repeat (5) step();
        chk("sat_uflow1_hold", 128'(uf1), 128'd15);
        clr1 = 1'b1;
        step();
        chk("sat_clr_uflow1", 128'(uf1), 128'(0));
        clr1 = 1'b0;

        // Reset while the high half is pending: that half must never come out.
        m1.tready = 1'b0; s1.tvalid = 1'b1; s1.tdata = word(128'd8, 128'd7);
        step();
        s1.tvalid = 1'b0;
        chk("mid_lo_tdata", m1.tdata, 128'd7);
        m1.tready = 1'b1;
        step();
        chk("mid_hi_tdata", m1.tdata, 128'd8);
        rstn = 1'b0;
        step();
        chk("mid_rst_tvalid", 128'(m1.tvalid), 128'(0));
        chk("mid_rst_tdata", m1.tdata, 128'(0));
        chk("mid_rst_aligned1", 128'(aligned1), 128'(0));
        chk("mid_rst_uflow1", 128'(uf1), 128'(0));
        chk("mid_rst_tready1", 128'(s1.tready), 128'(0));
        rstn = 1'b1;
        step();
        chk("post_rst_aligned1", 128'(aligned1), 128'(1));
        chk("post_rst_tvalid1", 128'(m1.tvalid), 128'(0));
        s1.tvalid = 1'b1; s1.tdata = word(128'd10, 128'd9);
        #1 chk("post_rst_tready1", 128'(s1.tready), 128'(1));
        step();
        s1.tvalid = 1'b0;
        chk("post_rst_lo_tdata", m1.tdata, 128'd9);
        chk("post_rst_lo_tvalid", 128'(m1.tvalid), 128'(1));
        step();
        chk("post_rst_hi_tdata", m1.tdata, 128'd10);
        step();
        chk("post_rst_drained", 128'(m1.tvalid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
